// File: rtl/jhcpu_p_if.sv
// jhcpu_p_if -- instruction/data memory bus of the jhcpu_p core.
//   iaddr  : instruction address (core -> memory)
//   idata  : instruction word, one cycle after iaddr (memory -> core)
//   daddr  : data address (core -> memory)
//   drdata : read data, one cycle after daddr (memory -> core)
//   dwdata : write data (core -> memory)
//   dwe    : one-cycle write strobe (core -> memory)
// modports: master = core side, slave = memory side.
interface jhcpu_p_if #(
    parameter int DW = 16,
    parameter int AW = 11
);
    logic [AW-1:0] iaddr;
    logic [AW+4:0] idata;
    logic [AW-1:0] daddr;
    logic [DW-1:0] drdata;
    logic [DW-1:0] dwdata;
    logic          dwe;

    modport master (output iaddr, daddr, dwdata, dwe, input idata, drdata);
    modport slave  (input iaddr, daddr, dwdata, dwe, output idata, drdata);
endinterface

// File: rtl/jhcpu_p.sv
// jhcpu_p -- small accumulator CPU, multi-cycle FETCH/DECODE/MEM/EXEC/HALT.
// Ports:
//   clock, reset (sync, active high), run (low holds the core in FETCH)
//   bus      : jhcpu_p_if.master (iaddr/idata, daddr/drdata/dwdata/dwe)
//   o/o_valid: output register and its update pulse
//   pc, da, zf, halted, stk_err : architectural state / status
// Optional feature: define JHCPU_MULDIV_EN to enable mult (0D) and divi (0E);
// otherwise both behave as 3-cycle NOPs.
// Effects decided in EXEC (da, pc, o, dwe) are registered, so o/o_valid and
// the dwe strobe become visible in the cycle after EXEC. A reset in EXEC thus
// cancels a pending store before it reaches the bus.
module jhcpu_p #(
    parameter int DW     = 16,
    parameter int AW     = 11,
    parameter int SDEPTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    jhcpu_p_if.master     bus,
    output logic [DW-1:0] o,
    output logic          o_valid,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] da,
    output logic          zf,
    output logic          halted,
    output logic          stk_err
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [4:0] OP_LDA  = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_OUT  = 5'h03;
    localparam logic [4:0] OP_SDAL = 5'h04;
    localparam logic [4:0] OP_SDAH = 5'h05;
    localparam logic [4:0] OP_STR  = 5'h06;
    localparam logic [4:0] OP_SUB  = 5'h07;
    localparam logic [4:0] OP_JMP  = 5'h08;
    localparam logic [4:0] OP_JZ   = 5'h09;
    localparam logic [4:0] OP_JN   = 5'h0A;
    localparam logic [4:0] OP_CALL = 5'h0B;
    localparam logic [4:0] OP_RET  = 5'h0C;
    localparam logic [4:0] OP_MULT = 5'h0D;
    localparam logic [4:0] OP_DIVI = 5'h0E;
    localparam logic [4:0] OP_STP  = 5'h1F;

    // one extra bit so the pointer can express "full" (== SDEPTH)
    localparam int SPW = $clog2(SDEPTH) + 1;

    logic [2:0]    r_state;
    logic [AW+4:0] r_ir;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_da;
    logic [DW-1:0] r_o;
    logic          r_ov;
    logic          r_dwe;
    logic          r_err;
    logic [SPW-1:0] r_sp;
    logic [AW-1:0] r_stk [SDEPTH];

    logic [4:0]     w_op;
    logic [4:0]     w_dec_op;
    logic [AW-1:0]  w_addr;
    logic [AW-1:0]  w_pc_inc;
    logic           w_memrd;
    logic           w_full;
    logic           w_empty;
    logic [SPW-2:0] w_top;
    logic [DW-1:0]  w_sdah;

    assign w_op     = r_ir[AW+4:AW];
    assign w_addr   = r_ir[AW-1:0];
    assign w_dec_op = bus.idata[AW+4:AW];
    assign w_pc_inc = r_pc + 1'b1;
    assign w_full   = (r_sp == SPW'(SDEPTH));
    assign w_empty  = (r_sp == '0);
    assign w_top    = (SPW-1)'(r_sp - SPW'(1));

    // sdah: byte 1 from imm, byte 0 kept, bits above 15 follow imm[7]
    always_comb begin
        w_sdah       = r_da;
        w_sdah[15:8] = w_addr[7:0];
        for (int i = 16; i < DW; i++) w_sdah[i] = w_addr[7];
    end

    // opcodes needing a data read get the extra MEM cycle
    always_comb begin
        w_memrd = 1'b0;
        case (w_dec_op)
            OP_LDA, OP_ADD, OP_OUT, OP_SUB: w_memrd = 1'b1;
`ifdef JHCPU_MULDIV_EN
            OP_MULT, OP_DIVI:               w_memrd = 1'b1;
`endif
            default:                        w_memrd = 1'b0;
        endcase
    end

`ifdef JHCPU_MULDIV_EN
    logic [DW-1:0] w_mul;
    logic [DW-1:0] w_div;
    assign w_mul = r_da * bus.drdata;
    assign w_div = (bus.drdata == '0) ? '1 : r_da / bus.drdata;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_pc    <= '0;
            r_da    <= '0;
            r_o     <= '0;
            r_ov    <= 1'b0;
            r_dwe   <= 1'b0;
            r_err   <= 1'b0;
            r_sp    <= '0;
        end else begin
            r_ov  <= 1'b0;
            r_dwe <= 1'b0;
            case (r_state)
                S_FETCH: if (run) r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir    <= bus.idata;
                    r_state <= w_memrd ? S_MEM : S_EXEC;
                end
                S_MEM: r_state <= S_EXEC;
                S_EXEC: begin
                    r_state <= S_FETCH;
                    r_pc    <= w_pc_inc;
                    case (w_op)
                        OP_LDA:  r_da <= bus.drdata;
                        OP_ADD:  r_da <= r_da + bus.drdata;
                        OP_SUB:  r_da <= r_da - bus.drdata;
                        OP_OUT: begin
                            r_o  <= bus.drdata;
                            r_ov <= 1'b1;
                        end
                        OP_SDAL: r_da <= {{(DW-8){w_addr[7]}}, w_addr[7:0]};
                        OP_SDAH: r_da <= w_sdah;
                        OP_STR:  r_dwe <= 1'b1;
                        OP_JMP:  r_pc <= w_addr;
                        OP_JZ:   if (r_da == '0) r_pc <= w_addr;
                        OP_JN:   if (r_da[DW-1]) r_pc <= w_addr;
                        OP_CALL: begin
                            if (w_full) begin
                                r_err   <= 1'b1;
                                r_state <= S_HALT;
                                r_pc    <= r_pc;
                            end else begin
                                r_sp <= r_sp + 1'b1;
                                r_pc <= w_addr;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                r_err   <= 1'b1;
                                r_state <= S_HALT;
                                r_pc    <= r_pc;
                            end else begin
                                r_sp <= r_sp - 1'b1;
                                r_pc <= r_stk[w_top];
                            end
                        end
`ifdef JHCPU_MULDIV_EN
                        OP_MULT: r_da <= w_mul;
                        OP_DIVI: r_da <= w_div;
`endif
                        OP_STP: begin
                            r_state <= S_HALT;
                            r_pc    <= r_pc;
                        end
                        default: ;
                    endcase
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // return-stack storage; only the pointer is reset
    always_ff @(posedge clock) begin
        if (!reset && r_state == S_EXEC && w_op == OP_CALL && !w_full)
            r_stk[r_sp[SPW-2:0]] <= w_pc_inc;
    end

    assign bus.iaddr  = r_pc;
    assign bus.daddr  = w_addr;
    assign bus.dwdata = r_da;
    assign bus.dwe    = r_dwe;

    assign o       = r_o;
    assign o_valid = r_ov;
    assign pc      = r_pc;
    assign da      = r_da;
    assign zf      = (r_da == '0);
    assign halted  = (r_state == S_HALT);
    assign stk_err = r_err;
endmodule

// File: tb/tb_jhcpu_p.sv
// tb_jhcpu_p -- directed bench for jhcpu_p (DW=16, AW=11, SDEPTH=2) with
// behavioural instruction/data memories and an o/o_valid scoreboard.
module tb_jhcpu_p;
    localparam int DW = 16;
    localparam int AW = 11;

    localparam logic [4:0] LDA = 5'h01, ADD = 5'h02, OUT = 5'h03, SDAL = 5'h04,
                           SDAH = 5'h05, STR = 5'h06, SUB = 5'h07, JMP = 5'h08,
                           JZ = 5'h09, JN = 5'h0A, CALL = 5'h0B, RET = 5'h0C,
                           MULT = 5'h0D, DIVI = 5'h0E, STP = 5'h1F;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run   = 1'b1;
    logic [DW-1:0] o;
    logic          o_valid;
    logic [AW-1:0] pc;
    logic [DW-1:0] da;
    logic          zf, halted, stk_err;

    jhcpu_p_if #(.DW(DW), .AW(AW)) bus ();

    jhcpu_p #(.DW(DW), .AW(AW), .SDEPTH(2)) dut (
        .clock(clock), .reset(reset), .run(run), .bus(bus),
        .o(o), .o_valid(o_valid), .pc(pc), .da(da), .zf(zf),
        .halted(halted), .stk_err(stk_err)
    );

    always #5 clock = ~clock;

    logic [AW+4:0] imem  [2**AW];
    logic [DW-1:0] dinit [2**AW];
    logic [DW-1:0] dmem  [2**AW];
    logic          mem_ld = 1'b0;
    logic [DW-1:0] exp_o [$];
    int n_chk  = 0;
    int n_pass = 0;

    // synchronous memories: read data one cycle after address
    always @(posedge clock) begin
        bus.idata  <= imem[bus.iaddr];
        bus.drdata <= dmem[bus.daddr];
        if (mem_ld) dmem <= dinit;
        else if (bus.dwe) dmem[bus.daddr] <= bus.dwdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // scoreboard: every o_valid pulse must match the next queued value
    always @(negedge clock) begin
        if (!reset && o_valid) begin
            if (exp_o.size() == 0) check("o_valid_unexpected", {31'd0, o_valid}, 32'd0);
            else begin
                logic [DW-1:0] e;
                e = exp_o.pop_front();
                check("o_value", {16'd0, o}, {16'd0, e});
            end
        end
    end

    function automatic logic [AW+4:0] ins(input logic [4:0] op, input int a);
        return {op, AW'(a)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2**AW; i++) begin
            imem[i]  = ins(STP, 0);
            dinit[i] = '0;
        end
        exp_o.delete();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        mem_ld = 1'b1;
        tick(1);
        mem_ld = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int maxc);
        int n;
        n = 0;
        while (!halted && n < maxc) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        // ---- reset state + run-low freeze + sdal/sdah ----
        clear_mem();
        imem[0] = ins(SDAL, 'h80);
        imem[1] = ins(SDAH, 'h12);
        imem[2] = ins(STP, 0);
        run = 1'b0;
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_da", da, 0);
        check("rst_o", {o_valid, o}, 0);
        check("rst_dwe", bus.dwe, 0);
        check("rst_flags", {halted, stk_err}, 0);
        check("rst_zf", zf, 1);
        tick(10);
        check("runlow_pc", {bus.iaddr, pc}, 0);
        check("runlow_da", {halted, da}, 0);
        run = 1'b1;
        tick(3);
        check("sdal_da", da, 'hFF80);
        check("sdal_pc", pc, 1);
        tick(3);
        check("sdah_da", da, 'h1280);
        run = 1'b0;
        tick(10);
        check("runlow2_state", {halted, pc, da}, {1'b0, 11'd2, 16'h1280});
        run = 1'b1;
        tick(3);
        check("stp_halt", {halted, pc}, {1'b1, 11'd2});

        // ---- arithmetic / branch / memory program ----
        clear_mem();
        dinit[3] = 16'd5; dinit[10] = 16'd4; dinit[20] = 16'h1111;
        imem[0] = ins(SDAL, 'hFF); imem[1] = ins(ADD, 3);   imem[2] = ins(JN, 7);
        imem[3] = ins(SUB, 10);    imem[4] = ins(JZ, 6);    imem[5] = ins(STP, 0);
        imem[6] = ins(OUT, 3);     imem[7] = ins(SDAL, 'h80); imem[8] = ins(STR, 20);
        imem[9] = ins(OUT, 20);    imem[10] = ins(JN, 12);  imem[11] = ins(STP, 0);
        imem[12] = ins(LDA, 3);    imem[13] = ins(JMP, 15); imem[14] = ins(STP, 0);
        imem[15] = ins(5'h10, 0);  imem[16] = ins(STP, 0);
        exp_o.push_back(16'd5);
        exp_o.push_back(16'hFF80);
        do_reset();
        tick(3);  check("p_sdal", da, 'hFFFF);
        tick(4);  check("p_add", {pc, da}, {11'd2, 16'h0004});
        tick(3);  check("p_jn_nt", {pc, zf}, {11'd3, 1'b0});
        tick(4);  check("p_sub", {zf, da}, {1'b1, 16'h0000});
        tick(3);  check("p_jz_t", pc, 6);
        tick(4);  check("p_out_pc", pc, 7);
        tick(3);  check("p_sdal80", da, 'hFF80);
        tick(3);  check("p_str_bus", {bus.dwe, bus.daddr, bus.dwdata}, {1'b1, 11'd20, 16'hFF80});
        tick(4);  check("p_str_mem", dmem[20], 'hFF80);
        tick(3);  check("p_jn_t", pc, 12);
        tick(4);  check("p_lda", da, 5);
        tick(3);  check("p_jmp", pc, 15);
        tick(3);  check("p_nop", {pc, da}, {11'd16, 16'd5});
        wait_halt("p_halt", 20);
        check("p_o_final", o, 'hFF80);
        check("p_sb_drain", exp_o.size(), 0);

        // ---- pc wrap ----
        clear_mem();
        imem[0] = ins(JMP, 2046); imem[2046] = '0; imem[2047] = '0;
        do_reset();
        tick(3); check("wrap_jmp", pc, 2046);
        tick(6); check("wrap_pc", pc, 0);

        // ---- call / ret ----
        clear_mem();
        imem[0] = ins(CALL, 4); imem[1] = ins(STP, 0);
        imem[4] = ins(CALL, 8); imem[5] = ins(RET, 0); imem[8] = ins(RET, 0);
        do_reset();
        tick(3); check("call1", pc, 4);
        tick(3); check("call2", pc, 8);
        tick(3); check("ret1", pc, 5);
        tick(3); check("ret2", pc, 1);
        wait_halt("callret_halt", 10);
        check("callret_noerr", {stk_err, pc}, {1'b0, 11'd1});

        // ---- stack overflow (depth 2) ----
        clear_mem();
        imem[0] = ins(CALL, 2); imem[2] = ins(CALL, 4); imem[4] = ins(CALL, 6);
        do_reset();
        tick(9);
        check("ovf_state", {stk_err, halted, pc}, {1'b1, 1'b1, 11'd4});
        tick(5);
        check("ovf_sticky", {stk_err, halted, pc}, {1'b1, 1'b1, 11'd4});

        // ---- stack underflow ----
        clear_mem();
        imem[0] = ins(RET, 0);
        do_reset();
        check("unf_rst_clear", {stk_err, halted}, 0);
        tick(3);
        check("unf_state", {stk_err, halted, pc}, {1'b1, 1'b1, 11'd0});

        // ---- reset during str EXEC cancels the write ----
        clear_mem();
        dinit[20] = 16'hAAAA;
        imem[0] = ins(SDAL, 'h33); imem[1] = ins(STR, 20);
        do_reset();
        tick(5);
        reset = 1'b1;
        tick(1);
        check("rststr_dwe_pc", {bus.dwe, pc, da}, 0);
        tick(1);
        check("rststr_mem", dmem[20], 'hAAAA);
        reset = 1'b0;

`ifdef JHCPU_MULDIV_EN
        // ---- 8! then divides ----
        clear_mem();
        dinit[32] = 16'd1; dinit[33] = 16'd0; dinit[34] = 16'h0080;
        imem[0] = ins(SDAL, 1);  imem[1] = ins(STR, 30);  imem[2] = ins(SDAL, 8);
        imem[3] = ins(STR, 31);  imem[4] = ins(LDA, 30);  imem[5] = ins(MULT, 31);
        imem[6] = ins(STR, 30);  imem[7] = ins(LDA, 31);  imem[8] = ins(SUB, 32);
        imem[9] = ins(STR, 31);  imem[10] = ins(JZ, 12);  imem[11] = ins(JMP, 4);
        imem[12] = ins(OUT, 30); imem[13] = ins(LDA, 30); imem[14] = ins(DIVI, 34);
        imem[15] = ins(STR, 35); imem[16] = ins(DIVI, 33); imem[17] = ins(STP, 0);
        exp_o.push_back(16'h9D80);
        do_reset();
        wait_halt("fact_halt", 2000);
        check("fact_o", o, 'h9D80);
        check("fact_div", dmem[35], 'h013B);
        check("fact_div0", da, 'hFFFF);
        check("fact_sb_drain", exp_o.size(), 0);
`else
        // ---- mult/divi are 3-cycle NOPs ----
        clear_mem();
        dinit[3] = 16'd7;
        imem[0] = ins(SDAL, 5); imem[1] = ins(MULT, 3); imem[2] = ins(DIVI, 3);
        do_reset();
        tick(6); check("mult_nop", {pc, da}, {11'd2, 16'd5});
        tick(3); check("divi_nop", {pc, da}, {11'd3, 16'd5});
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
